// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract over one shared 16-bit adder, LSB slice first; result valid WORDS cycles after accept.
// No overlap between requests; DONE holds all outputs stable until out_ready, in_valid ignored while busy.
module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_a,
  input  logic [16*WORDS-1:0]   in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic                  busy,
  output logic [15:0]           adder_a,
  output logic [15:0]           adder_b,
  output logic                  adder_cin,
  input  logic [15:0]           adder_sum,
  input  logic                  adder_cout
);

  localparam int N  = 16 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic            c0_q, c0_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            run;

  assign run = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c0_d    = c0_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          c0_d    = in_sub | in_cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{k_q, 4'b0000} +: 16] = adder_sum;
        carry_d = adder_cout;
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          // Overflow: operands agree in sign but the top slice's sum bit does not.
          cout_d  = adder_cout;
          ovf_d   = (a_q[N-1] == b_q[N-1]) & (adder_sum[15] != a_q[N-1]);
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c0_q    <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c0_q    <= c0_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // in_ready is gated by rst_n so it reads 0 throughout reset, not just after it.
  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign adder_a   = run ? a_q[{k_q, 4'b0000} +: 16] : 16'h0000;
  assign adder_b   = run ? b_q[{k_q, 4'b0000} +: 16] : 16'h0000;
  assign adder_cin = run & ((k_q == '0) ? c0_q : carry_q);

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: arithmetic reference model plus directed vectors with literal expectations.
module tb_wide_add_sequencer;
  localparam int WORDS = 4;
  localparam int N = 16 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_a = '0;
  logic [N-1:0]  in_b = '0;
  logic          in_cin = 1'b0;
  logic          in_sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic          busy;
  logic [15:0]   adder_a;
  logic [15:0]   adder_b;
  logic          adder_cin;
  logic [15:0]   adder_sum;
  logic          adder_cout;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .busy(busy),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout)
  );

  always #5 clk = ~clk;

  // External 16-bit adder.
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {16'd0, adder_cin};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL timeout_%s got no event expected event within bound at %0t", nm, $time);
  endtask

  // Reference model: result from wide arithmetic, handshake timing from the protocol rules.
  bit           m_run = 0, m_done = 0;
  int           m_k = 0;
  logic [N-1:0] m_sum = '0;
  bit           m_cout = 0, m_ovf = 0;
  logic [N-1:0] p_a, p_bp, p_sum, p_carries;
  bit           p_c0, p_cout, p_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_k = 0;
      m_sum = '0; m_cout = 0; m_ovf = 0;
    end else if (m_done) begin
      if (out_ready) m_done = 0;
    end else if (m_run) begin
      m_k++;
      if (m_k == WORDS) begin
        m_run = 0; m_done = 1;
        m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end
    end else if (in_valid) begin
      logic [N:0] full;
      p_a  = in_a;
      p_bp = in_sub ? ~in_b : in_b;
      p_c0 = in_sub ? 1'b1 : in_cin;
      full = {1'b0, p_a} + {1'b0, p_bp} + {{N{1'b0}}, p_c0};
      p_sum     = full[N-1:0];
      p_cout    = full[N];
      p_ovf     = (p_a[N-1] == p_bp[N-1]) && (full[N-1] != p_a[N-1]);
      p_carries = full[N-1:0] ^ p_a ^ p_bp;
      m_run = 1; m_k = 0;
    end
  end

  always @(negedge clk) begin
    check("in_ready", in_ready, rst_n && !m_run && !m_done);
    check("out_valid", out_valid, m_done);
    check("busy", busy, m_run || m_done);
    check("out_cout", out_cout, m_cout);
    check("out_ovf", out_ovf, m_ovf);
    if (!m_run) begin
      check("out_sum", out_sum, m_sum);
      check("adder_idle", {adder_a, adder_b, adder_cin}, '0);
    end else begin
      check("adder_a", adder_a, p_a[16*m_k +: 16]);
      check("adder_b", adder_b, p_bp[16*m_k +: 16]);
      check("adder_cin", adder_cin, (m_k == 0) ? p_c0 : p_carries[16*m_k]);
    end
  end

  int acc_cyc;

  // Called just after a rising edge; returns just after the accept edge.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin, input logic sub);
    bit ok = 0;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("accept");
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_valid(output int lat, output logic [3:0] cseq);
    bit ok = 0;
    cseq = 4'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
      if (busy) cseq = {cseq[2:0], adder_cin};
    end
    if (!ok) timeout("out_valid");
    lat = cyc - acc_cyc;
  endtask

  task automatic run_op(input string nm, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic sub,
                        input logic [N-1:0] es, input logic ec, input logic eo);
    int lat;
    logic [3:0] cs;
    start_op(a, b, cin, sub);
    wait_valid(lat, cs);
    check({nm, "_sum"}, out_sum, es);
    check({nm, "_cout"}, out_cout, ec);
    check({nm, "_ovf"}, out_ovf, eo);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [3:0] cs;
    int prev_acc;
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_sum", out_sum, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Slice carry into slice 1, latency and carry-in sequence.
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    wait_valid(lat, cs);
    check("t1_latency", lat, 4);
    check("t1_cin_seq", cs, 4'b0100);
    check("t1_sum", out_sum, 64'h0000_0000_0001_0000);
    check("t1_cout", out_cout, 1'b0);
    check("t1_ovf", out_ovf, 1'b0);
    @(posedge clk); #1;

    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub0m1", 64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("submin", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Backpressure: DONE held, new requests ignored.
    out_ready = 1'b0;
    start_op(64'h1234, 64'h1111, 1'b0, 1'b0);
    wait_valid(lat, cs);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_sum", out_sum, 64'h2345);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_after_valid", out_valid, 1'b0);
    check("bp_after_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Reset in the middle of an operation.
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_sum", out_sum, '0);
    check("mid_rst_flags", {out_cout, out_ovf}, 2'b00);
    check("mid_rst_adder", {adder_a, adder_b, adder_cin}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op("post_rst", 64'd5, 64'd3, 1'b0, 1'b0, 64'd8, 1'b0, 1'b0);

    // Back-to-back random operations.
    prev_acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bit ok = 0;
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      in_cin = $urandom_range(0, 1);
      in_sub = $urandom_range(0, 1);
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1; break; end
      end
      if (!ok) timeout("b2b_accept");
      if (i > 0) check("b2b_period", cyc - prev_acc, 6);
      prev_acc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    acc_cyc = cyc;
    wait_valid(lat, cs);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
